// File: rtl/axis_stream_arbiter.sv
// Packet-level round-robin merger of up to four AXI4-Stream sources onto one master.
// The grant is held from the first beat through the packet's tlast, or through a beat-limit forced tlast.
module axis_stream_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_NUM_SOURCES      = 2,
    parameter int C_MAX_PKT_BEATS    = 1024
) (
    input  logic                                         m_axis_aclk,
    input  logic                                         m_axis_aresetn,
    input  logic [C_NUM_SOURCES-1:0]                     s_axis_tvalid,
    output logic [C_NUM_SOURCES-1:0]                     s_axis_tready,
    input  logic [C_NUM_SOURCES*C_AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [C_NUM_SOURCES*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_SOURCES-1:0]                     s_axis_tlast,
    output logic                                         m_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic                                         m_axis_tlast,
    input  logic                                         m_axis_tready,
    output logic [C_NUM_SOURCES-1:0]                     grant,
    output logic                                         busy,
    output logic [31:0]                                  pkt_count,
    output logic                                         trunc_err,
    input  logic                                         clear
);

    localparam int          STRB_W    = C_AXIS_TDATA_WIDTH / 8;
    localparam int          IDX_W     = (C_NUM_SOURCES > 2) ? 2 : 1;
    localparam logic [15:0] LAST_BEAT = 16'(C_MAX_PKT_BEATS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]             state;
    logic [IDX_W-1:0]       gidx;
    logic [IDX_W-1:0]       last_grant;
    logic [15:0]            beat_cnt;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [C_NUM_SOURCES-1:0] win_onehot;

    logic                   src_last;
    logic                   at_limit;
    logic                   beat;
    logic                   eop;

    // Round-robin search: start one past the previous owner and wrap.
    always_comb begin
        int idx;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        idx        = 0;
        for (int k = 1; k <= C_NUM_SOURCES; k++) begin
            idx = (int'(last_grant) + k) % C_NUM_SOURCES;
            if (!win_found && s_axis_tvalid[idx]) begin
                win_found       = 1'b1;
                win_idx         = IDX_W'(idx);
                win_onehot[idx] = 1'b1;
            end
        end
    end

    // Handshake: a beat is m_axis_tvalid && m_axis_tready; the granted source sees
    // m_axis_tready directly, so source and master complete the same beat in the same cycle.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        s_axis_tready = '0;
        src_last      = 1'b0;
        if (state == ST_XFER) begin
            m_axis_tvalid       = s_axis_tvalid[gidx];
            m_axis_tdata        = s_axis_tdata[gidx*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
            m_axis_tstrb        = s_axis_tstrb[gidx*STRB_W +: STRB_W];
            s_axis_tready[gidx] = m_axis_tready;
            src_last            = s_axis_tlast[gidx];
        end
    end

    assign at_limit     = (state == ST_XFER) && (beat_cnt == LAST_BEAT);
    assign m_axis_tlast = src_last || at_limit;
    assign beat         = m_axis_tvalid && m_axis_tready;
    assign eop          = beat && m_axis_tlast;
    assign busy         = (state == ST_XFER);

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            gidx       <= '0;
            last_grant <= IDX_W'(C_NUM_SOURCES - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state <= ST_XFER;
                        grant <= win_onehot;
                        gidx  <= win_idx;
                    end
                end
                ST_XFER: begin
                    if (eop) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        last_grant <= gidx;
                        beat_cnt   <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Status: clear outranks a same-cycle increment or truncation flag.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            pkt_count <= '0;
            trunc_err <= 1'b0;
        end else if (clear) begin
            pkt_count <= '0;
            trunc_err <= 1'b0;
        end else begin
            if (eop) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (beat && at_limit && !src_last) begin
                trunc_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Directed bench for axis_stream_arbiter: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_axis_stream_arbiter;

    localparam int W = 64;
    localparam int N = 2;
    localparam int MAXB = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tready;
    logic [N*W-1:0] s_tdata;
    logic [N*W/8-1:0] s_tstrb;
    logic [N-1:0]   s_tlast;
    logic           m_tvalid;
    logic [W-1:0]   m_tdata;
    logic [W/8-1:0] m_tstrb;
    logic           m_tlast;
    logic           m_tready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [31:0]    pkt_count;
    logic           trunc_err;
    logic           clear;

    int n_cmp = 0;
    int n_bad = 0;

    axis_stream_arbiter #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_NUM_SOURCES(N),
        .C_MAX_PKT_BEATS(MAXB)
    ) dut (
        .m_axis_aclk(clk),
        .m_axis_aresetn(rst_n),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .s_axis_tstrb(s_tstrb),
        .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tdata(m_tdata),
        .m_axis_tstrb(m_tstrb),
        .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .grant(grant),
        .busy(busy),
        .pkt_count(pkt_count),
        .trunc_err(trunc_err),
        .clear(clear)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       clr;
        logic [1:0] vld;
        logic [1:0] lst;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] e_grant;
        logic       e_mv;
        logic [7:0] e_data;
        logic       e_ml;
        logic [1:0] e_sr;
        logic [31:0] e_pkt;
        logic       e_tr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [W-1:0] word(input int src, input logic [7:0] d);
        return {24'hC0FFEE, 8'(src), 24'h0, d};
    endfunction

    function automatic logic [7:0] strb_of(input int src);
        return (src == 0) ? 8'hFF : 8'h0F;
    endfunction

    task automatic add(input logic rst, input logic clr, input logic [1:0] vld,
                       input logic [1:0] lst, input logic [7:0] d0, input logic [7:0] d1,
                       input logic rdy, input logic [1:0] e_grant, input logic e_mv,
                       input logic [7:0] e_data, input logic e_ml, input logic [1:0] e_sr,
                       input logic [31:0] e_pkt, input logic e_tr);
        vec_t v;
        v.rst = rst; v.clr = clr; v.vld = vld; v.lst = lst; v.d0 = d0; v.d1 = d1;
        v.rdy = rdy; v.e_grant = e_grant; v.e_mv = e_mv; v.e_data = e_data;
        v.e_ml = e_ml; v.e_sr = e_sr; v.e_pkt = e_pkt; v.e_tr = e_tr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [1:0] lst,
                         input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
        s_tvalid = vld;
        s_tlast  = lst;
        s_tdata  = {word(1, d1), word(0, d0)};
        m_tready = rdy;
    endtask

    task automatic apply_row(input int i);
        vec_t v;
        int   src;
        v = vecs[i];
        @(posedge clk);
        #1;
        rst_n = v.rst;
        clear = v.clr;
        drive(v.vld, v.lst, v.d0, v.d1, v.rdy);
        @(negedge clk);
        src = (v.e_grant == 2'b10) ? 1 : 0;
        check($sformatf("row%0d grant", i), grant, v.e_grant);
        check($sformatf("row%0d busy", i), busy, (v.e_grant != 2'b00));
        check($sformatf("row%0d m_tvalid", i), m_tvalid, v.e_mv);
        check($sformatf("row%0d m_tlast", i), m_tlast, v.e_ml);
        check($sformatf("row%0d s_tready", i), s_tready, v.e_sr);
        check($sformatf("row%0d pkt_count", i), pkt_count, v.e_pkt);
        check($sformatf("row%0d trunc_err", i), trunc_err, v.e_tr);
        if (v.e_mv) begin
            check($sformatf("row%0d m_tdata", i), m_tdata, word(src, v.e_data));
            check($sformatf("row%0d m_tstrb", i), m_tstrb, strb_of(src));
        end
    endtask

    initial begin
        bit seen;

        s_tstrb = {8'h0F, 8'hFF};
        clear   = 1'b0;
        rst_n   = 1'b0;
        drive(2'b11, 2'b00, 8'h00, 8'h00, 1'b1);

        // reset held with every source requesting
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset grant", grant, 0);
        check("reset s_tready", s_tready, 0);
        check("reset m_tvalid", m_tvalid, 0);
        check("reset m_tlast", m_tlast, 0);
        check("reset busy", busy, 0);
        check("reset pkt_count", pkt_count, 0);
        check("reset trunc_err", trunc_err, 0);
        @(posedge clk);
        #1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;

        // rst clr vld   lst   d0     d1     rdy   grant  mv  data   ml  sr     pkt tr
        // single source, 4 beats
        add(1, 0, 2'b01, 2'b00, 8'h01, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 0, 0);
        add(1, 0, 2'b01, 2'b00, 8'h01, 8'h00, 1, 2'b01, 1, 8'h01, 0, 2'b01, 0, 0);
        add(1, 0, 2'b01, 2'b00, 8'h02, 8'h00, 1, 2'b01, 1, 8'h02, 0, 2'b01, 0, 0);
        add(1, 0, 2'b01, 2'b00, 8'h03, 8'h00, 1, 2'b01, 1, 8'h03, 0, 2'b01, 0, 0);
        add(1, 0, 2'b01, 2'b01, 8'h04, 8'h00, 1, 2'b01, 1, 8'h04, 1, 2'b01, 0, 0);
        add(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 1, 0);
        // fairness after reset: src0, src1, src0, src1
        add(0, 0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b00, 0, 8'h00, 0, 2'b00, 0, 0);
        add(1, 0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b00, 0, 8'h00, 0, 2'b00, 0, 0);
        add(1, 0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b01, 1, 8'h10, 0, 2'b01, 0, 0);
        add(1, 0, 2'b11, 2'b00, 8'h11, 8'h20, 1, 2'b01, 1, 8'h11, 0, 2'b01, 0, 0);
        add(1, 0, 2'b11, 2'b01, 8'h12, 8'h20, 1, 2'b01, 1, 8'h12, 1, 2'b01, 0, 0);
        add(1, 0, 2'b11, 2'b00, 8'h13, 8'h20, 1, 2'b00, 0, 8'h00, 0, 2'b00, 1, 0);
        add(1, 0, 2'b11, 2'b00, 8'h13, 8'h20, 1, 2'b10, 1, 8'h20, 0, 2'b10, 1, 0);
        add(1, 0, 2'b11, 2'b00, 8'h13, 8'h21, 1, 2'b10, 1, 8'h21, 0, 2'b10, 1, 0);
        add(1, 0, 2'b11, 2'b10, 8'h13, 8'h22, 1, 2'b10, 1, 8'h22, 1, 2'b10, 1, 0);
        add(1, 0, 2'b11, 2'b00, 8'h13, 8'h23, 1, 2'b00, 0, 8'h00, 0, 2'b00, 2, 0);
        add(1, 0, 2'b11, 2'b00, 8'h13, 8'h23, 1, 2'b01, 1, 8'h13, 0, 2'b01, 2, 0);
        add(1, 0, 2'b11, 2'b00, 8'h14, 8'h23, 1, 2'b01, 1, 8'h14, 0, 2'b01, 2, 0);
        add(1, 0, 2'b11, 2'b01, 8'h15, 8'h23, 1, 2'b01, 1, 8'h15, 1, 2'b01, 2, 0);
        add(1, 0, 2'b11, 2'b00, 8'h16, 8'h23, 1, 2'b00, 0, 8'h00, 0, 2'b00, 3, 0);
        add(1, 0, 2'b11, 2'b00, 8'h16, 8'h23, 1, 2'b10, 1, 8'h23, 0, 2'b10, 3, 0);
        add(1, 0, 2'b11, 2'b00, 8'h16, 8'h24, 1, 2'b10, 1, 8'h24, 0, 2'b10, 3, 0);
        add(1, 0, 2'b11, 2'b10, 8'h16, 8'h25, 1, 2'b10, 1, 8'h25, 1, 2'b10, 3, 0);
        add(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 4, 0);
        // backpressure on beat 2, plus a mid-packet tvalid drop that keeps the grant
        add(1, 0, 2'b01, 2'b00, 8'h31, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 4, 0);
        add(1, 0, 2'b01, 2'b00, 8'h31, 8'h00, 1, 2'b01, 1, 8'h31, 0, 2'b01, 4, 0);
        add(1, 0, 2'b01, 2'b00, 8'h32, 8'h00, 0, 2'b01, 1, 8'h32, 0, 2'b00, 4, 0);
        add(1, 0, 2'b01, 2'b00, 8'h32, 8'h00, 0, 2'b01, 1, 8'h32, 0, 2'b00, 4, 0);
        add(1, 0, 2'b01, 2'b00, 8'h32, 8'h00, 0, 2'b01, 1, 8'h32, 0, 2'b00, 4, 0);
        add(1, 0, 2'b01, 2'b00, 8'h32, 8'h00, 1, 2'b01, 1, 8'h32, 0, 2'b01, 4, 0);
        add(1, 0, 2'b00, 2'b00, 8'h33, 8'h00, 1, 2'b01, 0, 8'h00, 0, 2'b01, 4, 0);
        add(1, 0, 2'b01, 2'b00, 8'h33, 8'h00, 1, 2'b01, 1, 8'h33, 0, 2'b01, 4, 0);
        add(1, 0, 2'b01, 2'b01, 8'h34, 8'h00, 1, 2'b01, 1, 8'h34, 1, 2'b01, 4, 0);
        add(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 5, 0);
        // clear, then truncation of a 10-beat source-1 packet at the 8-beat limit
        add(1, 1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 5, 0);
        add(1, 0, 2'b10, 2'b00, 8'h00, 8'h41, 1, 2'b00, 0, 8'h00, 0, 2'b00, 0, 0);
        for (int b = 1; b <= 7; b++) begin
            add(1, 0, 2'b10, 2'b00, 8'h00, 8'(8'h40 + b), 1, 2'b10, 1, 8'(8'h40 + b), 0, 2'b10, 0, 0);
        end
        add(1, 0, 2'b10, 2'b00, 8'h00, 8'h48, 1, 2'b10, 1, 8'h48, 1, 2'b10, 0, 0);
        add(1, 0, 2'b10, 2'b00, 8'h00, 8'h49, 1, 2'b00, 0, 8'h00, 0, 2'b00, 1, 1);
        add(1, 0, 2'b10, 2'b00, 8'h00, 8'h49, 1, 2'b10, 1, 8'h49, 0, 2'b10, 1, 1);
        add(1, 0, 2'b10, 2'b10, 8'h00, 8'h4A, 1, 2'b10, 1, 8'h4A, 1, 2'b10, 1, 1);
        add(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 2, 1);
        add(1, 1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 2, 1);
        add(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 2'b00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_row(i);
        end

        // mid-packet reset at beat 2 of a source-0 packet
        @(posedge clk);
        #1;
        drive(2'b01, 2'b00, 8'h51, 8'h00, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (grant == 2'b01) seen = 1'b1;
        end
        check("mid grant_seen", seen, 1);
        @(posedge clk);
        #1;
        drive(2'b01, 2'b00, 8'h52, 8'h00, 1'b1);
        @(negedge clk);
        check("mid beat2 m_tdata", m_tdata, word(0, 8'h52));
        rst_n = 1'b0;
        #1;
        check("mid rst grant", grant, 0);
        check("mid rst s_tready", s_tready, 0);
        check("mid rst m_tvalid", m_tvalid, 0);
        check("mid rst m_tlast", m_tlast, 0);
        check("mid rst busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 8'h52, 8'h61, 1'b1);
        @(negedge clk);
        check("post rst idle grant", grant, 0);
        @(posedge clk);
        #1;
        check("post rst first grant", grant, 2'b01);
        check("post rst m_tdata", m_tdata, word(0, 8'h52));
        check("post rst s_tready", s_tready, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
